// File: rtl/proc_run_ctrl.sv
// Pushbutton-driven run sequencer for the board-level processor core.
// Debounces the key, issues step or free-run instructions, and latches results with a watchdog.
module proc_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter int unsigned DATA_W          = 16
) (
    input  logic              CLOCK_50,
    input  logic              Reset,
    input  logic              KeyN,
    input  logic              Mode,
    input  logic              Done,
    input  logic [DATA_W-1:0] DIn,
    output logic              Run,
    output logic              Busy,
    output logic [DATA_W-1:0] Result,
    output logic [DATA_W-1:0] StepCount,
    output logic              Fault
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_FAULT
    } state_t;

    logic [1:0]        sync_q;
    logic              deb_q, deb_d;
    logic [DB_W-1:0]   dbc_q, dbc_d;
    logic              press_q;

    state_t            state_q, state_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] step_q, step_d;
    logic              run_q, fault_q;

    // Debounce: count consecutive cycles of disagreement, accept the new level on the last one.
    always_comb begin
        deb_d = deb_q;
        dbc_d = '0;
        if (sync_q[1] != deb_q) begin
            if (dbc_q == DB_LAST) begin
                deb_d = sync_q[1];
            end else begin
                dbc_d = dbc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            sync_q  <= 2'b11;
            deb_q   <= 1'b1;
            dbc_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], KeyN};
            deb_q   <= deb_d;
            dbc_q   <= dbc_d;
            press_q <= deb_q & ~deb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        cap_d   = cap_q;
        res_d   = res_q;
        step_d  = step_q;
        case (state_q)
            S_IDLE: begin
                if (press_q) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Done wins over an expiring watchdog in the same cycle.
                if (Done) begin
                    cap_d   = DIn;
                    state_d = S_CAPTURE;
                end else if (wd_q == WD_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                res_d   = cap_q;
                step_d  = step_q + 1'b1;
                state_d = Mode ? S_ISSUE : S_IDLE;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q <= S_IDLE;
            wd_q    <= '0;
            cap_q   <= '0;
            res_q   <= '0;
            step_q  <= '0;
            run_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            cap_q   <= cap_d;
            res_q   <= res_d;
            step_q  <= step_d;
            run_q   <= (state_d == S_ISSUE) || (state_d == S_WAIT);
            fault_q <= (state_d == S_FAULT);
        end
    end

    assign Run       = run_q;
    assign Fault     = fault_q;
    assign Result    = res_q;
    assign StepCount = step_q;
    assign Busy      = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CAPTURE);

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Bench for proc_run_ctrl: instruction-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_proc_run_ctrl;

    localparam int unsigned DEB = 4;
    localparam int unsigned TO  = 8;
    localparam int unsigned W   = 16;

    logic         clk = 1'b0;
    logic         Reset = 1'b1;
    logic         KeyN = 1'b1;
    logic         Mode = 1'b0;
    logic         Done = 1'b0;
    logic [W-1:0] DIn = '0;
    logic         Run, Busy, Fault;
    logic [W-1:0] Result, StepCount;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;
    bit preload_req = 1'b0;

    proc_run_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TO),
        .DATA_W         (W)
    ) dut (
        .CLOCK_50 (clk),
        .Reset    (Reset),
        .KeyN     (KeyN),
        .Mode     (Mode),
        .Done     (Done),
        .DIn      (DIn),
        .Run      (Run),
        .Busy     (Busy),
        .Result   (Result),
        .StepCount(StepCount),
        .Fault    (Fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: key filter plus an instruction timeline.
    // m_age = cycles since Run rose (-1 when Run is low); m_capt marks the capture cycle.
    bit           m_k1 = 1'b1, m_k2 = 1'b1, m_deb = 1'b1, m_press = 1'b0;
    int           m_dbc = 0;
    int           m_age = -1;
    bit           m_capt = 1'b0, m_fault = 1'b0;
    logic [W-1:0] m_res = '0, m_dat = '0, m_cnt = '0;

    always @(posedge clk) begin
        bit new_press;
        if (Reset) begin
            m_k1 = 1'b1; m_k2 = 1'b1; m_deb = 1'b1; m_press = 1'b0; m_dbc = 0;
            m_age = -1; m_capt = 1'b0; m_fault = 1'b0;
            m_res = '0; m_dat = '0; m_cnt = '0;
        end else begin
            new_press = 1'b0;
            if (m_k2 != m_deb) begin
                if (m_dbc == int'(DEB) - 1) begin
                    m_deb = m_k2;
                    m_dbc = 0;
                    new_press = (m_k2 == 1'b0);
                end else begin
                    m_dbc++;
                end
            end else begin
                m_dbc = 0;
            end
            m_k2 = m_k1;
            m_k1 = KeyN;

            if (m_fault) begin
                m_age = -1;
            end else if (m_capt) begin
                m_capt = 1'b0;
                m_res  = m_dat;
                m_cnt  = m_cnt + 1'b1;
                m_age  = Mode ? 0 : -1;
            end else if (m_age >= 1) begin
                if (Done) begin
                    m_dat  = DIn;
                    m_capt = 1'b1;
                    m_age  = -1;
                end else if (m_age == int'(TO)) begin
                    m_fault = 1'b1;
                    m_age   = -1;
                end else begin
                    m_age++;
                end
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (m_press) begin
                m_age = 0;
            end
            m_press = new_press;
            if (preload_req) m_cnt = '1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_run",   32'(Run),       32'(m_age >= 0));
            check("model_busy",  32'(Busy),      32'((m_age >= 0) || m_capt));
            check("model_fault", 32'(Fault),     32'(m_fault));
            check("model_res",   32'(Result),    32'(m_res));
            check("model_cnt",   32'(StepCount), 32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (!Run && n < 40) begin
            tick();
            n++;
        end
        check("wait_run_bound", 32'(Run), 32'h1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int n, nr;

        // Reset
        Reset = 1'b1;
        tick();
        cmp_en = 1'b1;
        tick();
        check("rst_sync",  32'(dut.sync_q), 32'h3);
        check("rst_deb",   32'(dut.deb_q),  32'h1);
        check("rst_run",   32'(Run),        32'h0);
        check("rst_res",   32'(Result),     32'h0);
        check("rst_cnt",   32'(StepCount),  32'h0);
        check("rst_fault", 32'(Fault),      32'h0);
        Reset = 1'b0;
        tick();

        // Glitches alone never produce a press
        repeat (2) begin
            KeyN = 1'b0; tick();
            KeyN = 1'b1; repeat (3) tick();
        end
        repeat (10) tick();
        check("glitch_norun",  32'(Run),  32'h0);
        check("glitch_nobusy", 32'(Busy), 32'h0);

        // Clean press in step mode: Run after 2 + DEB + 1 cycles, Done 3 cycles after Run
        KeyN = 1'b0;
        n = 0;
        while (!Run && n < 20) begin
            tick();
            n++;
        end
        check("press_latency", 32'(n), 32'd7);
        repeat (3) tick();
        KeyN = 1'b1;
        Done = 1'b1;
        DIn  = 16'hA5C3;
        tick();
        Done = 1'b0;
        DIn  = 16'h0000;
        tick();
        check("step_res",  32'(Result),    32'hA5C3);
        check("step_cnt",  32'(StepCount), 32'd1);
        check("step_run",  32'(Run),       32'h0);
        check("step_busy", 32'(Busy),      32'h0);
        repeat (10) tick();

        // Free run: 5 instructions, a second press lands while busy, Mode cleared in 5th capture
        do_reset();
        Mode = 1'b1;
        fork
            begin
                KeyN = 1'b0; repeat (9) tick();
                KeyN = 1'b1; repeat (8) tick();
                KeyN = 1'b0; repeat (8) tick();
                KeyN = 1'b1;
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    int wn;
                    wait_run(wn);
                    tick();
                    tick();
                    Done = 1'b1;
                    DIn  = 16'h1000 + 16'(i);
                    tick();
                    Done = 1'b0;
                end
                Mode = 1'b0;
            end
        join
        repeat (12) tick();
        check("free_cnt",  32'(StepCount), 32'd5);
        check("free_res",  32'(Result),    32'h1004);
        check("free_run",  32'(Run),       32'h0);
        check("free_busy", 32'(Busy),      32'h0);

        // Watchdog: Done never arrives
        do_reset();
        KeyN = 1'b0;
        wait_run(n);
        KeyN = 1'b1;
        nr = 0;
        while (Run && nr < 30) begin
            tick();
            nr++;
        end
        check("to_run_cycles", 32'(nr),    32'd9);
        check("to_fault",      32'(Fault), 32'h1);
        check("to_run",        32'(Run),   32'h0);
        repeat (8) tick();
        KeyN = 1'b0;
        repeat (12) tick();
        KeyN = 1'b1;
        check("fault_sticky", 32'(Fault), 32'h1);
        check("fault_norun",  32'(Run),   32'h0);
        repeat (8) tick();
        Reset = 1'b1;
        tick();
        check("fault_clear", 32'(Fault), 32'h0);
        Reset = 1'b0;
        tick();

        // StepCount wrap, with Done on the final watchdog cycle
        cmp_en = 1'b0;
        force dut.step_q = '1;
        preload_req = 1'b1;
        tick();
        release dut.step_q;
        preload_req = 1'b0;
        cmp_en = 1'b1;
        check("preload_cnt", 32'(StepCount), 32'hFFFF);
        KeyN = 1'b0;
        wait_run(n);
        KeyN = 1'b1;
        repeat (8) tick();
        Done = 1'b1;
        DIn  = 16'h5A5A;
        tick();
        Done = 1'b0;
        DIn  = 16'h0000;
        tick();
        check("wrap_cnt",   32'(StepCount), 32'h0);
        check("wrap_res",   32'(Result),    32'h5A5A);
        check("prio_fault", 32'(Fault),     32'h0);
        check("prio_busy",  32'(Busy),      32'h0);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
